oled_spi_driver: RTL
====================

Name: oled_spi_driver

Overview:
- Downstream consumer of the image/status-bar byte source. It owns the 128x64 SSD1306 OLED over 4-wire write-only SPI.
- After power-up it resets the panel, sends a fixed init command sequence, then streams frames forever.
- Each frame is 6 addressing commands followed by 1024 data bytes. For each data byte it drives byte_counter and samples the returned byte_data.

Parameters:
- CLK_DIV, 2: clk cycles per SPI half-bit. sclk period = 2*CLK_DIV clk cycles; legal range 1..255.
- POWERUP_CYCLES, 50000: clk cycles oled_res_n is held low, and then also the wait after release.
- FRAME_BYTES, 1024: data bytes per frame (128 columns x 8 pages).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- byte_data  in  8  frame byte for the current byte_counter; valid 1 clk after byte_counter changes (registered upstream)
- byte_counter  out  10  index of the data byte being fetched, 0..FRAME_BYTES-1
- oled_sclk  out  1  SPI clock, idle low (mode 0)
- oled_mosi  out  1  SPI data, MSB first
- oled_cs_n  out  1  chip select, active low
- oled_dc  out  1  0 = command byte, 1 = display data byte
- oled_res_n  out  1  panel reset, active low
- frame_done  out  1  one-cycle pulse after the last data bit of a frame
- init_done  out  1  high from completion of the init sequence until reset

Behaviour:
- Decided interface: one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset values:
  - oled_sclk=0, oled_mosi=0, oled_cs_n=1, oled_dc=0, oled_res_n=0.
  - byte_counter=0, frame_done=0, init_done=0.
  - FSM enters PWR_RST.
- Reset mid-operation: on the next edge all outputs return to reset values and any byte in flight is aborted. cs_n must rise, never glitch low.
- FSM states and transitions:
  - PWR_RST: res_n=0 for POWERUP_CYCLES, then -> PWR_WAIT.
  - PWR_WAIT: res_n=1 for POWERUP_CYCLES, then -> INIT.
  - INIT: send the 25-byte command ROM with dc=0, in this order: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF. After the last byte, set init_done=1 -> ADDR.
  - ADDR: send commands 21 00 7F 22 00 07 with dc=0 (column 0..127, page 0..7, horizontal mode), then -> FETCH with byte_counter=0.
  - FETCH: hold byte_counter stable for exactly 2 clk cycles. Latch byte_data into the shifter on the 2nd edge, then -> DATA.
  - DATA: send the latched byte with dc=1.
    - If byte_counter < FRAME_BYTES-1: increment byte_counter -> FETCH.
    - Otherwise: pulse frame_done, set byte_counter=0 -> ADDR.
  - Frames repeat indefinitely; the ROM is never resent without reset.
- Byte transfer (shared shifter):
  - cs_n falls and dc/mosi(bit7) are set in the same cycle. One half-bit later sclk rises; after a further half-bit sclk falls and mosi advances.
  - 8 bits MSB first; the panel samples on the rising sclk edge.
  - After the 8th falling edge, cs_n rises and stays high for CLK_DIV cycles (inter-byte gap) before the next byte.
  - One byte = 16*CLK_DIV + CLK_DIV clk cycles including the gap.
  - dc and mosi are stable whenever sclk is high.
- Width rules:
  - Half-bit divider is 8 bits, bit counter 3 bits, ROM index 5 bits.
  - byte_counter never exceeds FRAME_BYTES-1 and wraps to 0 only via the frame_done path.
  - PWR counter is wide enough for POWERUP_CYCLES (17 bits at default).
- byte_data is sampled only in FETCH. Changes at any other time have no effect on the byte in flight.

Test Plan:
- Reset, POWERUP_CYCLES=4: reset high 3 cycles -> all outputs at reset values. After release, res_n low 4 cycles, then high 4 cycles, then cs_n falls.
- Init capture, CLK_DIV=2: sample mosi on each sclk rise -> first byte 0xAE with dc=0, 25 bytes total matching the ROM exactly. init_done rises after the 25th byte; each byte takes 34 clk cycles.
- Addressing: after init, the next 6 bytes are 21 00 7F 22 00 07 with dc=0, then the first data byte has dc=1 and byte_counter=0.
- Data path: model upstream as a registered byte_data = byte_counter[7:0] XOR 0x5A -> every captured data byte equals its index pattern (e.g. index 3 -> 0x59), byte_counter sweeps 0..1023 in order.
- Frame wrap: after byte 1023 -> frame_done high exactly 1 cycle, byte_counter=0, next bytes are the 6 addressing commands again; the second frame is identical to the first.
- Reset mid-byte: assert reset during bit 4 of a data byte -> cs_n=1, sclk=0, res_n=0 on the next edge, followed by a full power-up and init repeat.

Source files
------------

// File: rtl/oled_spi_driver.sv
// SSD1306 128x64 OLED driver over write-only 4-wire SPI (mode 0, MSB first).
// Powers up the panel, sends the init ROM once, then streams addressed frames forever.
module oled_spi_driver #(
  parameter int CLK_DIV        = 2,
  parameter int POWERUP_CYCLES = 50000,
  parameter int FRAME_BYTES    = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_data,
  output logic [9:0] byte_counter,
  output logic       oled_sclk,
  output logic       oled_mosi,
  output logic       oled_cs_n,
  output logic       oled_dc,
  output logic       oled_res_n,
  output logic       frame_done,
  output logic       init_done
);

  localparam int              PWR_W      = $clog2(POWERUP_CYCLES) + 1;
  localparam logic [PWR_W-1:0] PWR_LAST  = PWR_W'(POWERUP_CYCLES - 1);
  localparam logic [7:0]      DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [9:0]      BC_LAST    = 10'(FRAME_BYTES - 1);
  localparam logic [4:0]      INIT_LAST  = 5'd24;
  localparam logic [4:0]      ADDR_LAST  = 5'd5;

  typedef enum logic [2:0] {
    PWR_RST, PWR_WAIT, INIT, ADDR, FETCH, DATA
  } state_t;

  typedef enum logic [1:0] {
    SH_IDLE, SH_LOW, SH_HIGH, SH_GAP
  } sh_t;

  state_t           r_state;
  sh_t              r_sh;
  logic [PWR_W-1:0] r_pwr_cnt;
  logic [7:0]       r_div;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [4:0]       r_idx;
  logic             r_fetch;
  logic [9:0]       r_byte_counter;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_cs_n;
  logic             r_dc;
  logic             r_res_n;
  logic             r_frame_done;
  logic             r_init_done;

  logic             w_byte_end;
  logic             w_launch;
  logic [7:0]       w_tx_byte;
  logic             w_tx_dc;
  logic [4:0]       w_idx_nxt;

  function automatic logic [7:0] init_rom(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'hAE;
      5'd1:  v = 8'hD5;
      5'd2:  v = 8'h80;
      5'd3:  v = 8'hA8;
      5'd4:  v = 8'h3F;
      5'd5:  v = 8'hD3;
      5'd6:  v = 8'h00;
      5'd7:  v = 8'h40;
      5'd8:  v = 8'h8D;
      5'd9:  v = 8'h14;
      5'd10: v = 8'h20;
      5'd11: v = 8'h00;
      5'd12: v = 8'hA1;
      5'd13: v = 8'hC8;
      5'd14: v = 8'hDA;
      5'd15: v = 8'h12;
      5'd16: v = 8'h81;
      5'd17: v = 8'hCF;
      5'd18: v = 8'hD9;
      5'd19: v = 8'hF1;
      5'd20: v = 8'hDB;
      5'd21: v = 8'h40;
      5'd22: v = 8'hA4;
      5'd23: v = 8'hA6;
      5'd24: v = 8'hAF;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Column window 0..127, page window 0..7 (horizontal addressing set in init).
  function automatic logic [7:0] addr_rom(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0: v = 8'h21;
      5'd1: v = 8'h00;
      5'd2: v = 8'h7F;
      5'd3: v = 8'h22;
      5'd4: v = 8'h00;
      5'd5: v = 8'h07;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  assign w_byte_end = (r_sh == SH_GAP) && (r_div == DIV_LAST);
  assign w_idx_nxt  = r_idx + 5'd1;

  // Next byte is launched on the same edge the previous gap ends, so bytes run back to back.
  always_comb begin
    w_launch  = 1'b0;
    w_tx_byte = 8'h00;
    w_tx_dc   = 1'b0;
    case (r_state)
      PWR_WAIT: if (r_pwr_cnt == PWR_LAST) begin
        w_launch  = 1'b1;
        w_tx_byte = init_rom(5'd0);
      end
      INIT: if (w_byte_end) begin
        w_launch  = 1'b1;
        w_tx_byte = (r_idx == INIT_LAST) ? addr_rom(5'd0) : init_rom(w_idx_nxt);
      end
      ADDR: if (w_byte_end && (r_idx != ADDR_LAST)) begin
        w_launch  = 1'b1;
        w_tx_byte = addr_rom(w_idx_nxt);
      end
      FETCH: if (r_fetch) begin
        w_launch  = 1'b1;
        w_tx_byte = byte_data;
        w_tx_dc   = 1'b1;
      end
      DATA: if (w_byte_end && (r_byte_counter == BC_LAST)) begin
        w_launch  = 1'b1;
        w_tx_byte = addr_rom(5'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= PWR_RST;
      r_sh           <= SH_IDLE;
      r_pwr_cnt      <= '0;
      r_div          <= '0;
      r_bit          <= '0;
      r_idx          <= '0;
      r_fetch        <= 1'b0;
      r_byte_counter <= '0;
      r_sclk         <= 1'b0;
      r_mosi         <= 1'b0;
      r_cs_n         <= 1'b1;
      r_dc           <= 1'b0;
      r_res_n        <= 1'b0;
      r_frame_done   <= 1'b0;
      r_init_done    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      // Shared SPI shifter: LOW/HIGH half-bits, then a cs_n-high gap.
      if (w_launch) begin
        r_shift <= w_tx_byte;
        r_mosi  <= w_tx_byte[7];
        r_dc    <= w_tx_dc;
        r_cs_n  <= 1'b0;
        r_sclk  <= 1'b0;
        r_sh    <= SH_LOW;
        r_div   <= '0;
        r_bit   <= '0;
      end else begin
        case (r_sh)
          SH_LOW: begin
            if (r_div == DIV_LAST) begin
              r_div  <= '0;
              r_sclk <= 1'b1;
              r_sh   <= SH_HIGH;
            end else begin
              r_div <= r_div + 8'd1;
            end
          end
          SH_HIGH: begin
            if (r_div == DIV_LAST) begin
              r_div  <= '0;
              r_sclk <= 1'b0;
              if (r_bit == 3'd7) begin
                r_cs_n <= 1'b1;
                r_sh   <= SH_GAP;
              end else begin
                r_bit   <= r_bit + 3'd1;
                r_shift <= {r_shift[6:0], 1'b0};
                r_mosi  <= r_shift[6];
                r_sh    <= SH_LOW;
              end
            end else begin
              r_div <= r_div + 8'd1;
            end
          end
          SH_GAP: begin
            if (r_div == DIV_LAST) begin
              r_div <= '0;
              r_sh  <= SH_IDLE;
            end else begin
              r_div <= r_div + 8'd1;
            end
          end
          default: ;
        endcase
      end

      // Sequencer
      case (r_state)
        PWR_RST: begin
          if (r_pwr_cnt == PWR_LAST) begin
            r_pwr_cnt <= '0;
            r_res_n   <= 1'b1;
            r_state   <= PWR_WAIT;
          end else begin
            r_pwr_cnt <= r_pwr_cnt + 1'b1;
          end
        end
        PWR_WAIT: begin
          if (r_pwr_cnt == PWR_LAST) begin
            r_pwr_cnt <= '0;
            r_idx     <= '0;
            r_state   <= INIT;
          end else begin
            r_pwr_cnt <= r_pwr_cnt + 1'b1;
          end
        end
        INIT: begin
          if (w_byte_end) begin
            if (r_idx == INIT_LAST) begin
              r_init_done <= 1'b1;
              r_idx       <= '0;
              r_state     <= ADDR;
            end else begin
              r_idx <= w_idx_nxt;
            end
          end
        end
        ADDR: begin
          if (w_byte_end) begin
            if (r_idx == ADDR_LAST) begin
              r_idx          <= '0;
              r_byte_counter <= '0;
              r_fetch        <= 1'b0;
              r_state        <= FETCH;
            end else begin
              r_idx <= w_idx_nxt;
            end
          end
        end
        FETCH: begin
          // Upstream registers byte_data, so it is only valid on the second edge.
          if (r_fetch) begin
            r_fetch <= 1'b0;
            r_state <= DATA;
          end else begin
            r_fetch <= 1'b1;
          end
        end
        DATA: begin
          if (w_byte_end) begin
            if (r_byte_counter == BC_LAST) begin
              r_frame_done   <= 1'b1;
              r_byte_counter <= '0;
              r_idx          <= '0;
              r_state        <= ADDR;
            end else begin
              r_byte_counter <= r_byte_counter + 10'd1;
              r_fetch        <= 1'b0;
              r_state        <= FETCH;
            end
          end
        end
        default: r_state <= PWR_RST;
      endcase
    end
  end

  assign byte_counter = r_byte_counter;
  assign oled_sclk    = r_sclk;
  assign oled_mosi    = r_mosi;
  assign oled_cs_n    = r_cs_n;
  assign oled_dc      = r_dc;
  assign oled_res_n   = r_res_n;
  assign frame_done   = r_frame_done;
  assign init_done    = r_init_done;

endmodule
